// File: rtl/pts_tx_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pts_tx_pkg
// Purpose  : Shared types and helpers for the PTS transmit sequencer.
// Revision : 1.0  initial release
// ============================================================================
package pts_tx_pkg;

  // Sequencer states; the explicit width keeps the encoding stable.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_t;

  // Bits needed to hold the values 0..count-1. The result is never less than 1,
  // so a degenerate count still gets a legal vector.
  function automatic int cnt_width(input int count);
    return (count <= 2) ? 1 : $clog2(count);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pts_tx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pts_tx_ctrl_if
// Purpose  : Upstream word handshake plus the PTS control bundle.
//            master = word source / PTS side, slave = sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface pts_tx_ctrl_if #(
  parameter int NUM_BITS = 8
);
  logic [NUM_BITS-1:0] data_in;
  logic                data_valid;
  logic                data_ready;
  logic                abort;
  logic                load_enable;
  logic                shift_enable;
  logic [NUM_BITS-1:0] pts_data;
  logic                tx_active;
  logic                word_done;

  modport master (
    output data_in, data_valid, abort,
    input  data_ready, load_enable, shift_enable, pts_data, tx_active, word_done
  );

  modport slave (
    input  data_in, data_valid, abort,
    output data_ready, load_enable, shift_enable, pts_data, tx_active, word_done
  );
endinterface
`default_nettype wire

// File: rtl/pts_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : pts_bit_timer
// Purpose  : Rollover counter 0..rollover_val with synchronous clear.
//            rollover_flag is combinational and marks the terminal count.
// Revision : 1.0  initial release
// ============================================================================
module pts_bit_timer #(
  parameter int WIDTH = 4
) (
  input  wire logic             clk,
  input  wire logic             n_rst,
  input  wire logic             clear,
  input  wire logic             count_enable,
  input  wire logic [WIDTH-1:0] rollover_val,
  output logic                  rollover_flag
);
  logic [WIDTH-1:0] count;

  assign rollover_flag = (count == rollover_val);

  // Count up on enable; wrap to zero after the terminal value; clear wins.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_enable) begin
      count <= rollover_flag ? '0 : count + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/pts_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pts_tx_ctrl
// Purpose  : Paces words from a valid/ready source into an idle-high
//            parallel-to-serial shifter, one bit every CLKS_PER_BIT clocks,
//            with optional inter-word gap and synchronous abort.
// Revision : 1.0  initial release
// ============================================================================
module pts_tx_ctrl
  import pts_tx_pkg::*;
#(
  parameter int NUM_BITS     = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int GAP_PERIODS  = 0
) (
  input  wire logic     clk,
  input  wire logic     n_rst,
  pts_tx_ctrl_if.slave  bus
);
  localparam int CLK_W     = cnt_width(CLKS_PER_BIT);
  localparam int BIT_W     = cnt_width(NUM_BITS);
  localparam int GAP_TOTAL = GAP_PERIODS * CLKS_PER_BIT;
  localparam int GAP_W     = cnt_width(GAP_TOTAL);

  localparam logic [CLK_W-1:0] CLK_LAST = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  tx_state_t           state;
  tx_state_t           next_state;
  logic                armed;
  logic                clk_flag;
  logic                bit_flag;
  logic                gap_flag;
  logic                abort_hit;
  logic                ready;
  logic                load;
  logic                shift;
  logic                done;
  logic [NUM_BITS-1:0] load_word;

  // abort is ignored until the first clock after reset release.
  assign abort_hit = armed && bus.abort;

  // armed rises on the first clock after reset release and stays high.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  // Clocks within a bit period; it wraps at the boundary, which also restarts
  // the period on a seamless back-to-back reload.
  pts_bit_timer #(.WIDTH(CLK_W)) u_clk_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (abort_hit || (state != SHIFT)),
    .count_enable (state == SHIFT),
    .rollover_val (CLK_LAST),
    .rollover_flag(clk_flag)
  );

  // Bit index within the word; it advances only on bit boundaries.
  pts_bit_timer #(.WIDTH(BIT_W)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (abort_hit || (state != SHIFT)),
    .count_enable ((state == SHIFT) && clk_flag),
    .rollover_val (BIT_LAST),
    .rollover_flag(bit_flag)
  );

  generate
    if (GAP_PERIODS > 0) begin : g_gap
      pts_bit_timer #(.WIDTH(GAP_W)) u_gap_timer (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (abort_hit || (state != GAP)),
        .count_enable (state == GAP),
        .rollover_val (GAP_W'(GAP_TOTAL - 1)),
        .rollover_flag(gap_flag)
      );
    end else begin : g_no_gap
      assign gap_flag = 1'b0;
    end
  endgenerate

  // Next-state and output decode; abort overrides everything at the end.
  always_comb begin
    next_state = state;
    ready      = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    done       = 1'b0;
    load_word  = '1;
    case (state)
      IDLE: begin
        ready = armed && !bus.abort;
        if (ready && bus.data_valid) begin
          load       = 1'b1;
          load_word  = bus.data_in;
          next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (clk_flag) begin
          if (!bit_flag) begin
            shift = 1'b1;
          end else begin
            done = 1'b1;
            if (GAP_PERIODS == 0) begin
              ready = 1'b1;
              if (bus.data_valid) begin
                load      = 1'b1;
                load_word = bus.data_in;
              end else begin
                shift      = 1'b1;
                next_state = IDLE;
              end
            end else begin
              shift      = 1'b1;
              next_state = GAP;
            end
          end
        end
      end
      GAP: begin
        if (gap_flag) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    if (abort_hit) begin
      next_state = IDLE;
      ready      = 1'b0;
      load       = 1'b1;
      shift      = 1'b0;
      done       = 1'b0;
      load_word  = '1;
    end
  end

  assign bus.data_ready   = ready;
  assign bus.load_enable  = load;
  assign bus.shift_enable = shift;
  assign bus.word_done    = done;
  assign bus.pts_data     = load_word;
  assign bus.tx_active    = (state != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_pts_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pts_tx_ctrl
// Purpose  : Self-checking bench: two sequencers (no gap / two-period gap),
//            each driving a behavioural idle-high PTS, compared every cycle
//            against a phase-arithmetic model of the transmit schedule.
// Revision : 1.0  initial release
// ============================================================================
module tb_pts_tx_ctrl;
  localparam int NB  = 8;
  localparam int CPB = 4;
  localparam int P   = NB * CPB;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  pts_tx_ctrl_if #(.NUM_BITS(NB)) bus0 ();
  pts_tx_ctrl_if #(.NUM_BITS(NB)) bus1 ();

  pts_tx_ctrl #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB), .GAP_PERIODS(0)) dut0 (
    .clk(clk), .n_rst(n_rst), .bus(bus0.slave));
  pts_tx_ctrl #(.NUM_BITS(NB), .CLKS_PER_BIT(CPB), .GAP_PERIODS(2)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(bus1.slave));

  // Stimulus drive.
  logic [NB-1:0] drv_data [2];
  logic          drv_valid[2];
  logic          drv_abort[2];
  assign bus0.data_in    = drv_data[0];
  assign bus0.data_valid = drv_valid[0];
  assign bus0.abort      = drv_abort[0];
  assign bus1.data_in    = drv_data[1];
  assign bus1.data_valid = drv_valid[1];
  assign bus1.abort      = drv_abort[1];

  // Behavioural MSB-first PTS, idle-high, fills with ones.
  logic [NB-1:0] pts0, pts1;
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 pts0 <= '1;
    else if (bus0.load_enable)  pts0 <= bus0.pts_data;
    else if (bus0.shift_enable) pts0 <= {pts0[NB-2:0], 1'b1};
  end
  always @(posedge clk or negedge n_rst) begin
    if (!n_rst)                 pts1 <= '1;
    else if (bus1.load_enable)  pts1 <= bus1.pts_data;
    else if (bus1.shift_enable) pts1 <= {pts1[NB-2:0], 1'b1};
  end

  // Observed outputs per instance.
  logic          o_ready[2], o_load[2], o_shift[2], o_done[2], o_tx[2], o_ser[2];
  logic [NB-1:0] o_pts[2];
  assign o_ready[0] = bus0.data_ready;   assign o_ready[1] = bus1.data_ready;
  assign o_load[0]  = bus0.load_enable;  assign o_load[1]  = bus1.load_enable;
  assign o_shift[0] = bus0.shift_enable; assign o_shift[1] = bus1.shift_enable;
  assign o_done[0]  = bus0.word_done;    assign o_done[1]  = bus1.word_done;
  assign o_tx[0]    = bus0.tx_active;    assign o_tx[1]    = bus1.tx_active;
  assign o_pts[0]   = bus0.pts_data;     assign o_pts[1]   = bus1.pts_data;
  assign o_ser[0]   = pts0[NB-1];        assign o_ser[1]   = pts1[NB-1];

  // Source queues, stimulus requests, model state, counters.
  logic [NB-1:0] q0[$];
  logic [NB-1:0] q1[$];
  logic          rst_req;
  logic          abort_req[2];
  int            ld_cyc[2];     // cycle of the most recent load, -1 if none
  logic [NB-1:0] mdl_word[2];
  bit            armed_m;
  int            caps[2];
  int            dones[2];
  int            cyc;
  int            checks;
  int            errors;

  task automatic chk(input string tag, input int i, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s inst%0d cyc%0d observed=%0h expected=%0h", tag, i, cyc, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [NB-1:0] w);
    if (i == 0) q0.push_back(w);
    else        q1.push_back(w);
  endtask

  // Expected behaviour from the word's phase: bit k occupies phases
  // k*CPB+1 .. (k+1)*CPB after the load cycle; the gap follows phase P.
  task automatic eval_inst(input int i);
    logic          e_ready, e_load, e_shift, e_done, e_tx, e_ser;
    logic [NB-1:0] e_pts;
    int            ph, g;
    bit            in_word, in_gap, xfer;
    g       = (i == 0) ? 0 : 2;
    e_ready = 0; e_load = 0; e_shift = 0; e_done = 0; e_tx = 0; e_ser = 1;
    e_pts   = '1;
    xfer    = 0;
    ph      = (ld_cyc[i] >= 0) ? cyc - ld_cyc[i] : -1;
    in_word = (ph >= 1) && (ph <= P);
    in_gap  = (g > 0) && (ph > P) && (ph <= P + g * CPB);
    if (n_rst && in_word) e_ser = mdl_word[i][NB - 1 - (ph - 1) / CPB];
    if (n_rst && armed_m) begin
      e_tx = in_word || in_gap;
      if (drv_abort[i]) begin
        e_load = 1;
      end else if (!in_word && !in_gap) begin
        e_ready = 1;
      end else if (in_word) begin
        if ((ph % CPB == 0) && (ph < P)) e_shift = 1;
        if (ph == P) begin
          e_done = 1;
          if (g == 0) e_ready = 1;
          if (g != 0 || !drv_valid[i]) e_shift = 1;
        end
      end
      if (e_ready && drv_valid[i]) begin
        e_load = 1;
        e_pts  = drv_data[i];
        xfer   = 1;
      end
    end
    chk("data_ready",   i, 32'(o_ready[i]), 32'(e_ready));
    chk("load_enable",  i, 32'(o_load[i]),  32'(e_load));
    chk("shift_enable", i, 32'(o_shift[i]), 32'(e_shift));
    chk("word_done",    i, 32'(o_done[i]),  32'(e_done));
    chk("tx_active",    i, 32'(o_tx[i]),    32'(e_tx));
    chk("pts_data",     i, 32'(o_pts[i]),   32'(e_pts));
    chk("serial_out",   i, 32'(o_ser[i]),   32'(e_ser));
    if (e_done) dones[i]++;
    if (!n_rst || (armed_m && drv_abort[i])) ld_cyc[i] = -1;
    if (xfer) begin
      ld_cyc[i]   = cyc;
      mdl_word[i] = drv_data[i];
      caps[i]++;
      if (i == 0) void'(q0.pop_front());
      else        void'(q1.pop_front());
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      n_rst        = rst_req;
      drv_abort[0] = abort_req[0];
      drv_abort[1] = abort_req[1];
      drv_valid[0] = (q0.size() != 0);
      if (q0.size() != 0) drv_data[0] = q0[0];
      drv_valid[1] = (q1.size() != 0);
      if (q1.size() != 0) drv_data[1] = q1[0];
      #1;
      eval_inst(0);
      eval_inst(1);
      armed_m = n_rst;
      cyc++;
    end
  endtask

  initial begin
    int c0, d0;
    checks = 0; errors = 0; cyc = 0; armed_m = 0;
    rst_req = 0; abort_req[0] = 0; abort_req[1] = 0;
    drv_data[0] = '0; drv_data[1] = '0;
    drv_valid[0] = 0; drv_valid[1] = 0; drv_abort[0] = 0; drv_abort[1] = 0;
    ld_cyc[0] = -1; ld_cyc[1] = -1; caps[0] = 0; caps[1] = 0;
    dones[0] = 0; dones[1] = 0;
    mdl_word[0] = '1; mdl_word[1] = '1;

    // Reset, release, first cycle after release, then armed.
    run(3);
    rst_req = 1;
    run(3);

    // Single word 0xA5.
    push(0, 8'hA5);
    run(40);
    chk("single_done_count", 0, 32'(dones[0]), 32'd1);

    // Back-to-back 0x3C, 0xFF with valid held.
    push(0, 8'h3C); push(0, 8'hFF);
    run(70);
    chk("b2b_done_count", 0, 32'(dones[0]), 32'd3);

    // Abort at t+10 during 0x00.
    d0 = dones[0];
    push(0, 8'h00);
    run(10);
    abort_req[0] = 1; run(1); abort_req[0] = 0;
    run(30);
    chk("abort_no_done", 0, 32'(dones[0] - d0), 32'd0);

    // Gap instance: 0x81 twice.
    push(1, 8'h81); push(1, 8'h81);
    run(90);
    chk("gap_done_count", 1, 32'(dones[1]), 32'd2);

    // Reset at t+6 of a word on both instances.
    d0 = dones[0];
    push(0, 8'h5A); push(1, 8'h5A);
    run(6);
    rst_req = 0; run(3);
    rst_req = 1; run(4);
    chk("reset_no_done", 0, 32'(dones[0] - d0), 32'd0);

    // Valid held while busy: 0x55 waits for the final boundary.
    c0 = caps[0];
    push(0, 8'hC3);
    run(1);
    push(0, 8'h55);
    run(45);
    chk("captured_once", 0, 32'(caps[0] - c0), 32'd2);

    // Randomised streaming with occasional aborts and resets.
    for (int k = 0; k < 3000; k++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) == 0) push(0, NB'($urandom));
      if (q1.size() == 0 && $urandom_range(0, 3) == 0) push(1, NB'($urandom));
      abort_req[0] = ($urandom_range(0, 49) == 0);
      abort_req[1] = ($urandom_range(0, 49) == 0);
      rst_req      = ($urandom_range(0, 799) != 0);
      run(1);
    end
    abort_req[0] = 0; abort_req[1] = 0; rst_req = 1;
    run(80);
    chk("drained_q0", 0, 32'(q0.size()), 32'd0);
    chk("drained_q1", 1, 32'(q1.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pts_tx_ctrl.md
Name: pts_tx_ctrl

Overview:
Transmit sequencer for a flex parallel-to-serial shift register (PTS) that is idle-high and fills with ones. It accepts words from an upstream source over a valid/ready handshake and drives the PTS load_enable, shift_enable and parallel_in. It paces one bit per CLKS_PER_BIT clocks and supports back-to-back streaming, an optional inter-word idle gap, and a synchronous abort. It sits between the packet/encoder logic and the PTS instance.

Parameters:
NUM_BITS, 8, word width; must match the PTS NUM_BITS (>=2)
CLKS_PER_BIT, 8, clocks per serial bit period (>=2)
GAP_PERIODS, 0, idle bit periods forced between words (0 = seamless streaming)

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  asynchronous active-low reset
data_in  input  NUM_BITS  word to transmit, MSB first
data_valid  input  1  upstream has a word on data_in
data_ready  output  1  controller accepts data_in this cycle
abort  input  1  synchronous abort of the current word
load_enable  output  1  to PTS load_enable
shift_enable  output  1  to PTS shift_enable
pts_data  output  NUM_BITS  to PTS parallel_in
tx_active  output  1  high while a word or gap is in progress
word_done  output  1  one-cycle pulse on the final bit boundary of a word

Behaviour:
- Clock and reset: one clock, clk. Reset n_rst is asynchronous, active-low.
- State register: states IDLE, SHIFT, GAP.
- Counters: clk_cnt counts 0..CLKS_PER_BIT-1; bit_cnt counts 0..NUM_BITS-1.
- armed flop: 0 in reset, set to 1 on the first clk after reset release.
- Reset values: state IDLE, counters 0, armed 0.
- While in reset and on the first cycle after release, all outputs are 0, except pts_data = all ones.
- All outputs are combinational from state, counters and inputs; zero-latency handshake.
- Handshake: transfer occurs when data_valid && data_ready at a rising edge. data_valid may be held indefinitely; data_in must be stable while valid and not ready.
- IDLE:
  - data_ready = armed && !abort.
  - On transfer: load_enable=1 and pts_data=data_in in the same cycle. Next state SHIFT with clk_cnt=0, bit_cnt=0.
- SHIFT:
  - clk_cnt increments each cycle.
  - Bit boundary is clk_cnt==CLKS_PER_BIT-1; clk_cnt wraps to 0 there.
  - Non-final boundary (bit_cnt<NUM_BITS-1): shift_enable=1, bit_cnt++.
  - Final boundary (bit_cnt==NUM_BITS-1): word_done=1.
    - If GAP_PERIODS==0: data_ready=!abort. On transfer, load_enable=1 (shift_enable=0), pts_data=data_in, stay in SHIFT with counters cleared. Otherwise shift_enable=1, go to IDLE.
    - If GAP_PERIODS>0: data_ready=0, shift_enable=1, go to GAP.
  - data_ready=0 on all other SHIFT cycles.
- Serial timing: each bit occupies exactly CLKS_PER_BIT cycles on serial_out. The first bit appears the cycle after load. Exactly NUM_BITS shift/load events per word.
- GAP:
  - Counts GAP_PERIODS*CLKS_PER_BIT cycles with data_ready=0.
  - On the last count, go to IDLE. A new word can be accepted in the following cycle.
- abort=1 in any state (after armed):
  - load_enable=1, pts_data=all ones (forces line idle-high).
  - shift_enable=0, data_ready=0, word_done=0.
  - Next state IDLE, counters cleared.
  - abort has priority over every other event.
- tx_active = (state != IDLE).
- pts_data = all ones whenever load_enable=0.
- Reset mid-word: immediate return to IDLE; the PTS resets to all ones independently; no word_done.

Decomposition:
- Package pts_tx_pkg:
  - state enum typedef tx_state_t {IDLE, SHIFT, GAP}.
  - Helper localparams for counter widths via $clog2 of CLKS_PER_BIT, NUM_BITS and GAP_PERIODS*CLKS_PER_BIT (min width 1).
- Sub-module pts_bit_timer: parameterised rollover counter with clear, count_enable, rollover_val and a rollover_flag output.
  - Instantiated for clk_cnt, bit_cnt and the gap counter.
  - FSM and output decode stay in pts_tx_ctrl.

Test Plan:
Use NUM_BITS=8, CLKS_PER_BIT=4, GAP_PERIODS=0 unless stated, with a real flex PTS (SHIFT_MSB=1) attached.
1. Single word: 0xA5 with valid at cycle t.
   - load_enable at t.
   - shift_enable at t+4, t+8, …, t+28 (7 pulses), final shift and word_done at t+32.
   - serial_out = 1,0,1,0,0,1,0,1, each 4 cycles, then 1; tx_active falls after t+32.
2. Back-to-back: 0x3C then 0xFF, valid held high.
   - Second load_enable at t+32 with no shift that cycle; word_done at t+32 and t+64.
   - No idle cycle on serial_out between words.
3. Abort at t+10 during 0x00.
   - load_enable=1 with pts_data=0xFF at t+10; serial_out=1 from t+11; state IDLE.
   - No word_done; data_ready=1 at t+11.
4. GAP_PERIODS=2: send 0x81 twice.
   - word_done at t+32; data_ready=0 for t+32..t+40.
   - Second load_enable no earlier than t+41.
5. Reset: assert n_rst low at t+6 of a word.
   - All outputs 0, pts_data=all ones, serial_out=1.
   - data_ready stays 0 on the first cycle after release and is 1 on the second.
6. Valid held while busy: data_valid high with 0x55 from t+1.
   - data_ready=0 on t+1..t+31; transfer at t+32 only.
   - data_in=0x55 captured exactly once.
